axis_adc_frame_packer: RTL and testbench

Downstream stage of the dual-channel AD7276 acquisition wrapper. It snapshots all 2·ADC_QTD conversion results when a conversion completes, then serialises them as one AXI4-Stream packet of tagged 16-bit words, one word per channel, for the DMA/FIFO path. It counts emitted frames, and counts frames dropped because the previous packet was still draining.

---
 rtl/adc_pkg.sv | 27 ++
 rtl/adc_eoc_edge_detect.sv | 24 ++
 rtl/axis_adc_frame_packer.sv | 111 +++++++++++
 tb/tb_axis_adc_frame_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, types and helpers for the AD7276 acquisition path.
// Word layout on the stream: [15:12] channel tag, [11:0] zero-extended sample.
package adc_pkg;

    localparam int CH_TAG_W       = 4;
    localparam int AXIS_W         = 16;
    localparam int SAMPLE_FIELD_W = 12;
    localparam int MAX_CH         = 2 ** CH_TAG_W;

    typedef enum logic {
        IDLE,
        STREAM
    } pack_state_t;

    function automatic bit params_ok(input int adc_length, input int num_ch);
        return (adc_length >= 1) && (adc_length <= SAMPLE_FIELD_W) &&
               (num_ch >= 2) && (num_ch <= MAX_CH);
    endfunction

    function automatic logic [AXIS_W-1:0] pack_word(
        input logic [CH_TAG_W-1:0]       tag,
        input logic [SAMPLE_FIELD_W-1:0] sample
    );
        return {tag, sample};
    endfunction

endpackage

// File: rtl/adc_eoc_edge_detect.sv
// Registered rising-edge detector; the history bit resets high so a level
// already asserted when reset releases does not count as a fresh edge.
module adc_eoc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/axis_adc_frame_packer.sv
// Snapshots all ADC channels on an eoc rising edge and streams them as one
// AXI4-Stream packet of tagged 16-bit words, with frame and overrun counters.
module axis_adc_frame_packer
    import adc_pkg::*;
#(
    parameter int ADC_LENGTH = 12,
    parameter int ADC_QTD    = 8
) (
    input  logic                              CLK100MHz,
    input  logic                              ARESET,
    input  logic                              enable,
    input  logic [2*ADC_QTD*ADC_LENGTH-1:0]   adc_data,
    input  logic                              eoc,
    output logic [AXIS_W-1:0]                 m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [15:0]                       frame_count,
    output logic [7:0]                        overrun_count,
    output logic                              busy
);

    localparam int NUM_CH = 2 * ADC_QTD;
    localparam logic [CH_TAG_W-1:0] LAST_CH = CH_TAG_W'(NUM_CH - 1);

    if (!params_ok(ADC_LENGTH, NUM_CH)) begin : g_param_check
        $error("axis_adc_frame_packer: ADC_LENGTH or channel count out of range");
    end

    pack_state_t                    state;
    logic [CH_TAG_W-1:0]            ch_idx;
    logic [NUM_CH*ADC_LENGTH-1:0]   snapshot;
    logic [SAMPLE_FIELD_W-1:0]      sample_ext;
    logic                           eoc_rise;
    logic                           cap_req;
    logic                           hs;
    logic                           last_hs;

    adc_eoc_edge_detect u_eoc_edge (
        .clk  (CLK100MHz),
        .rst  (ARESET),
        .d    (eoc),
        .rise (eoc_rise)
    );

    assign cap_req = eoc_rise & enable;
    assign busy    = (state == STREAM);
    assign hs      = busy & m_axis_tready;
    assign last_hs = hs & (ch_idx == LAST_CH);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sample_ext = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == CH_TAG_W'(k)) begin
                sample_ext[ADC_LENGTH-1:0] = snapshot[k*ADC_LENGTH +: ADC_LENGTH];
            end
        end
    end

    // Outputs follow snapshot/ch_idx directly, so they cannot move mid-stall.
    assign m_axis_tvalid = busy;
    assign m_axis_tlast  = busy & (ch_idx == LAST_CH);
    assign m_axis_tdata  = busy ? pack_word(ch_idx, sample_ext) : '0;

    // NOTE: the snapshot is an ordinary register bank, so it is reset with the
    // rest of the state; that keeps tdata at zero out of reset.
    always_ff @(posedge CLK100MHz) begin
        if (ARESET) begin
            state         <= IDLE;
            ch_idx        <= '0;
            snapshot      <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cap_req) begin
                        snapshot <= adc_data;
                        ch_idx   <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_hs) begin
                        frame_count <= frame_count + 16'd1;
                        ch_idx      <= '0;
                        // A capture landing on the closing beat chains the next packet.
                        if (cap_req) begin
                            snapshot <= adc_data;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (hs) begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                        if (cap_req && (overrun_count != 8'hFF)) begin
                            overrun_count <= overrun_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_adc_frame_packer.sv
// Scoreboard bench for axis_adc_frame_packer with ADC_QTD=2 (4 channels):
// stimulus queues the expected beats, a negedge monitor pops and compares.
module tb_axis_adc_frame_packer;

    localparam int ADC_LENGTH = 12;
    localparam int ADC_QTD    = 2;
    localparam int NUM_CH     = 2 * ADC_QTD;

    logic                                clk;
    logic                                areset;
    logic                                enable;
    logic [NUM_CH*ADC_LENGTH-1:0]        adc_data;
    logic                                eoc;
    logic [15:0]                         tdata;
    logic                                tvalid;
    logic                                tready;
    logic                                tlast;
    logic [15:0]                         frame_count;
    logic [7:0]                          overrun_count;
    logic                                busy;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];

    axis_adc_frame_packer #(
        .ADC_LENGTH (ADC_LENGTH),
        .ADC_QTD    (ADC_QTD)
    ) dut (
        .CLK100MHz     (clk),
        .ARESET        (areset),
        .enable        (enable),
        .adc_data      (adc_data),
        .eoc           (eoc),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Loads the sample bus and queues the four expected beats of that frame.
    task automatic set_frame(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3);
        logic [11:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        adc_data = {s3, s2, s1, s0};
        for (int k = 0; k < NUM_CH; k++) begin
            exp_q.push_back({(k == NUM_CH - 1), 4'(k), s[k]});
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, " idle_within_budget"}, 32'(busy), 32'd0);
    endtask

    // Monitor: compares each accepted beat and holds stalled beats steady.
    initial begin : monitor
        logic        stalled;
        logic [16:0] held;
        logic [16:0] cur;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                stalled = 1'b0;
            end else if (tvalid) begin
                cur = {tlast, tdata};
                if (stalled) check("stall_stable", 32'(cur), 32'(held));
                if (tready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_beat queue_size", 32'(exp_q.size()), 32'd1);
                    else
                        check("beat {tlast,tdata}", 32'(cur), 32'(exp_q.pop_front()));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else begin
                if (stalled) check("valid_dropped_in_stall", 32'(tvalid), 32'd1);
                stalled = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [15:0] fc0;
        logic [7:0]  oc0;
        areset   = 1'b1;
        enable   = 1'b1;
        eoc      = 1'b0;
        tready   = 1'b1;
        adc_data = '0;
        tick(3);

        check("reset tvalid", 32'(tvalid), 32'd0);
        check("reset tlast", 32'(tlast), 32'd0);
        check("reset tdata", 32'(tdata), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset overrun_count", 32'(overrun_count), 32'd0);
        areset = 1'b0;
        tick(2);

        // Basic packet, tready held high.
        set_frame(12'h111, 12'h222, 12'h333, 12'h444);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("latency tvalid", 32'(tvalid), 32'd1);
        check("latency tdata", 32'(tdata), 32'h0111);
        wait_idle("basic", 10);
        check("basic frame_count", 32'(frame_count), 32'd1);

        // Same frame with back-pressure pattern 1,0,0,1,0,1,1.
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            set_frame(12'h111, 12'h222, 12'h333, 12'h444);
            eoc = 1'b1;
            tick();
            eoc = 1'b0;
            for (int i = 0; i < 7; i++) begin
                tready = pat[i];
                tick();
            end
            tready = 1'b1;
            check("stall packet done busy", 32'(busy), 32'd0);
            check("stall frame_count", 32'(frame_count), 32'd2);
        end

        // Second eoc edge during beat 1 is dropped; new bus values never appear.
        set_frame(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        adc_data = {12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC};
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        wait_idle("overrun", 10);
        check("overrun_count one", 32'(overrun_count), 32'd1);
        check("overrun frame_count", 32'(frame_count), 32'd3);

        // 300 more drops while stalled on beat 0: counter saturates.
        tready = 1'b0;
        set_frame(12'h5A0, 12'h5A1, 12'h5A2, 12'h5A3);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            eoc = 1'b1;
            tick();
            eoc = 1'b0;
            tick();
        end
        check("overrun_count saturated", 32'(overrun_count), 32'hFF);
        tready = 1'b1;
        wait_idle("saturate", 10);
        check("saturate frame_count", 32'(frame_count), 32'd4);

        // Capture coincident with the last-beat handshake chains with no gap.
        fc0 = frame_count;
        set_frame(12'h123, 12'h456, 12'h789, 12'hABC);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick(3);
        check("b2b frame_count before", 32'(frame_count), 32'(fc0));
        set_frame(12'hFED, 12'hCBA, 12'h987, 12'h654);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("b2b tvalid no gap", 32'(tvalid), 32'd1);
        check("b2b tdata new ch0", 32'(tdata), 32'h0FED);
        check("b2b frame_count after first", 32'(frame_count), 32'(fc0 + 16'd1));
        wait_idle("b2b", 10);
        check("b2b frame_count after second", 32'(frame_count), 32'(fc0 + 16'd2));

        // Reset mid-packet after two beats, eoc held high across release.
        set_frame(12'h321, 12'h654, 12'h987, 12'hCBA);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick(2);
        areset = 1'b1;
        eoc    = 1'b1;
        tick();
        check("midreset tvalid", 32'(tvalid), 32'd0);
        check("midreset frame_count", 32'(frame_count), 32'd0);
        check("midreset overrun_count", 32'(overrun_count), 32'd0);
        areset = 1'b0;
        exp_q.delete();
        tick(5);
        check("eoc held high no packet", 32'(busy), 32'd0);
        eoc = 1'b0;
        tick();
        set_frame(12'h00F, 12'h0F0, 12'hF00, 12'h0FF);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("post-reset capture tvalid", 32'(tvalid), 32'd1);
        wait_idle("post-reset", 10);
        check("post-reset frame_count", 32'(frame_count), 32'd1);

        // enable low blocks captures but never truncates a packet in flight.
        oc0 = overrun_count;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eoc = 1'b1;
            tick();
            eoc = 1'b0;
            tick();
            check("disabled no capture busy", 32'(busy), 32'd0);
        end
        check("disabled overrun_count", 32'(overrun_count), 32'(oc0));
        check("disabled frame_count", 32'(frame_count), 32'd1);
        enable = 1'b1;
        set_frame(12'h777, 12'h888, 12'h999, 12'hAAA);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        enable = 1'b0;
        wait_idle("enable-mid", 10);
        check("enable-mid frame_count", 32'(frame_count), 32'd2);
        enable = 1'b1;

        tick(2);
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
